// File: rtl/core_pkg.sv
// Shared types and constants for the SHA-256 core input streamer:
// FSM state encoding, padding words, block geometry and the latched job record.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } stream_state_t;

   // First padding word (the single '1' bit after the 640-bit message).
   localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
   // Message length in bits, placed in the last word of the block.
   localparam logic [31:0] LEN_WORD   = 32'h0000_0280;
   localparam int          NUM_WORDS  = 16;
   localparam int          WORD_IDX_W = $clog2(NUM_WORDS);

   // Header-chunk fields captured when a job is accepted.
   typedef struct packed {
      logic [31:0] merkle_tail;
      logic [31:0] timestamp;
      logic [31:0] nbits;
   } job_t;

endpackage

// File: rtl/core_input_streamer_block_word_mux.sv
// block_word_mux: selects the 32-bit message word for a given word index
// from the latched job, the current nonce and the fixed padding words.
module block_word_mux
   import core_pkg::*;
#(
   parameter int          NONCE_W   = 32,
   parameter logic [31:0] LAST_WORD = core_pkg::LEN_WORD
) (
   input  logic [WORD_IDX_W-1:0] word_idx,
   input  job_t                  job,
   input  logic [NONCE_W-1:0]    nonce,
   output logic [31:0]           w
);

   // Word layout of one padded block; every unlisted index is zero padding.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
      w = '0;
      case (word_idx)
         4'd0:    w = job.merkle_tail;
         4'd1:    w = job.timestamp;
         4'd2:    w = job.nbits;
         4'd3:    w = 32'(nonce);
         4'd4:    w = PAD_WORD;
         4'd15:   w = LAST_WORD;
         default: w = '0;
      endcase
   end

endmodule

// File: rtl/core_input_streamer.sv
// core_input_streamer: accepts one mining job and streams one padded 512-bit
// block per nonce to the SHA-256 core, one word per accepted cycle.
// Optional feature: define STREAM_ABORT_EN to add the 'abort' input, which
// drops the block in flight and ends the job through DONE.
module core_input_streamer #(
   parameter int          NONCE_W  = 32,
   parameter logic [31:0] LEN_WORD = core_pkg::LEN_WORD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [31:0]        merkle_tail,
   input  logic [31:0]        timestamp,
   input  logic [31:0]        nbits,
   input  logic [NONCE_W-1:0] nonce_start,
   input  logic [NONCE_W-1:0] nonce_count,
   input  logic               core_ready,
`ifdef STREAM_ABORT_EN
   input  logic               abort,
`endif
   output logic               valid,
   output logic               newblock,
   output logic [31:0]        w,
   output logic [NONCE_W-1:0] cur_nonce,
   output logic               done
);

   import core_pkg::*;

   stream_state_t           state, state_n;
   logic [WORD_IDX_W-1:0]   word_idx, word_idx_n;
   logic [NONCE_W-1:0]      nonce, nonce_n;
   logic [NONCE_W-1:0]      remaining, remaining_n;
   job_t                    job, job_n;
   logic [31:0]             w_n;
   logic                    abort_req;

`ifdef STREAM_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Word for the next cycle, chosen from the next-state index, job and nonce.
   block_word_mux #(
      .NONCE_W   (NONCE_W),
      .LAST_WORD (LEN_WORD)
   ) u_word_mux (
      .word_idx (word_idx_n),
      .job      (job_n),
      .nonce    (nonce_n),
      .w        (w_n)
   );

   // Next-state logic: job acceptance, word/nonce stepping and job completion.
   always_comb begin
      state_n     = state;
      word_idx_n  = word_idx;
      nonce_n     = nonce;
      remaining_n = remaining;
      job_n       = job;
      unique case (state)
         IDLE: begin
            if (job_valid && job_ready) begin
               job_n = '{merkle_tail: merkle_tail, timestamp: timestamp, nbits: nbits};
               if (nonce_count != '0) begin
                  word_idx_n  = '0;
                  nonce_n     = nonce_start;
                  remaining_n = nonce_count;
                  state_n     = STREAM;
               end else begin
                  state_n = DONE;
               end
            end
         end
         STREAM: begin
            // valid is high throughout STREAM, so core_ready alone marks acceptance.
            if (abort_req) begin
               state_n = DONE;
            end else if (core_ready) begin
               if (word_idx == WORD_IDX_W'(NUM_WORDS - 1)) begin
                  word_idx_n  = '0;
                  nonce_n     = nonce + NONCE_W'(1);
                  remaining_n = remaining - NONCE_W'(1);
                  if (remaining == NONCE_W'(1)) begin
                     state_n = DONE;
                  end
               end else begin
                  word_idx_n = word_idx + WORD_IDX_W'(1);
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State and registered outputs, all derived from the next-state values so every output is a flop.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
      if (rst) begin
         // NOTE: the job record is reset alongside the control state so nothing stale can reach w after reset.
         state     <= IDLE;
         word_idx  <= '0;
         nonce     <= '0;
         remaining <= '0;
         job       <= '0;
         valid     <= 1'b0;
         newblock  <= 1'b0;
         w         <= '0;
         cur_nonce <= '0;
         done      <= 1'b0;
         job_ready <= 1'b1;
      end else begin
         state     <= state_n;
         word_idx  <= word_idx_n;
         nonce     <= nonce_n;
         remaining <= remaining_n;
         job       <= job_n;
         valid     <= (state_n == STREAM);
         newblock  <= (state_n == STREAM) && (word_idx_n == '0);
         w         <= (state_n == STREAM) ? w_n : '0;
         cur_nonce <= nonce_n;
         done      <= (state_n == DONE);
         job_ready <= (state_n == IDLE);
      end
   end

endmodule

// File: tb/tb_core_input_streamer.sv
// Self-checking bench for core_input_streamer: table-driven jobs plus random
// jobs, compared against a queue-based model of the block word sequence.
module tb_core_input_streamer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        job_valid = 1'b0;
   logic        core_ready = 1'b0;
   logic [31:0] merkle_tail = '0, timestamp = '0, nbits = '0;
   logic [31:0] nonce_start = '0, nonce_count = '0;
   logic        job_ready, valid, newblock, done;
   logic [31:0] w, cur_nonce;
`ifdef STREAM_ABORT_EN
   logic        abort = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] w;
      logic        nb;
      logic [31:0] nonce;
      int          idx;
   } exp_t;

   typedef struct {
      logic [31:0] mt, ts, nb, start, count;
      bit          bp;
      int          exp_words;
      logic [31:0] exp_last_w3;
   } vec_t;

   exp_t q[$];
   vec_t vecs[6];

   core_input_streamer dut (
      .clk         (clk),
      .rst         (rst),
      .job_valid   (job_valid),
      .job_ready   (job_ready),
      .merkle_tail (merkle_tail),
      .timestamp   (timestamp),
      .nbits       (nbits),
      .nonce_start (nonce_start),
      .nonce_count (nonce_count),
      .core_ready  (core_ready),
`ifdef STREAM_ABORT_EN
      .abort       (abort),
`endif
      .valid       (valid),
      .newblock    (newblock),
      .w           (w),
      .cur_nonce   (cur_nonce),
      .done        (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; outputs are sampled here and inputs changed here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected accepted word stream for a job: one 16-word block per nonce.
   task automatic build_model(input vec_t v);
      logic [31:0] blk [16];
      logic [31:0] n;
      q.delete();
      for (int b = 0; b < int'(v.count); b++) begin
         n   = v.start + 32'(b);
         blk = '{v.mt, v.ts, v.nb, n, 32'h8000_0000,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0280};
         for (int k = 0; k < 16; k++)
            q.push_back('{w: blk[k], nb: (k == 0), nonce: n, idx: k});
      end
   endtask

   task automatic run_job(input vec_t v, input string tag);
      int          accepted;
      int          cycles;
      int          budget;
      logic [31:0] last_w3;
      logic [31:0] seen_w;
      bit          cr;
      exp_t        e;
      accepted = 0;
      cycles   = 0;
      last_w3  = '0;
      check({tag, " job_ready before"}, 128'(job_ready), 128'(1));
      merkle_tail = v.mt;
      timestamp   = v.ts;
      nbits       = v.nb;
      nonce_start = v.start;
      nonce_count = v.count;
      job_valid   = 1'b1;
      core_ready  = 1'b1;
      build_model(v);
      step();
      // Scramble the job inputs: the streamer must use its latched copy.
      job_valid   = 1'b0;
      merkle_tail = $urandom;
      timestamp   = $urandom;
      nbits       = $urandom;
      nonce_start = $urandom;
      budget = int'(v.count) * 16 * 8 + 20;
      while (q.size() != 0 && cycles < budget) begin
         e = q[0];
         check({tag, " word"}, 128'({valid, newblock, w, cur_nonce}),
               128'({1'b1, e.nb, e.w, e.nonce}));
         seen_w = w;
         cr = v.bp ? 1'($urandom_range(1, 0)) : 1'b1;
         core_ready = cr;
         // A competing job while busy must be ignored.
         job_valid   = 1'($urandom);
         nonce_count = $urandom_range(0, 4);
         step();
         cycles++;
         if (cr) begin
            if (valid || seen_w == e.w) accepted++;
            if (e.idx == 3) last_w3 = seen_w;
            void'(q.pop_front());
         end
      end
      if (q.size() != 0)
         check({tag, " stream timeout, words left"}, 128'(q.size()), 128'(0));
      job_valid  = 1'b0;
      core_ready = 1'b0;
      check({tag, " done pulse {valid,done,job_ready}"}, 128'({valid, done, job_ready}), 128'(3'b010));
      step();
      check({tag, " back to idle {valid,done,job_ready}"}, 128'({valid, done, job_ready}), 128'(3'b001));
      check({tag, " accepted words"}, 128'(accepted), 128'(v.exp_words));
      if (v.exp_words > 0)
         check({tag, " last nonce word"}, 128'(last_w3), 128'(v.exp_last_w3));
   endtask

   initial begin
      vec_t rv;

      vecs[0] = '{mt: 32'hA1B2_C3D4, ts: 32'h5F5E_0F00, nb: 32'h1D00_FFFF, start: 32'h0,
                  count: 32'd1, bp: 1'b0, exp_words: 16, exp_last_w3: 32'h0};
      vecs[1] = '{mt: 32'hA1B2_C3D4, ts: 32'h5F5E_0F00, nb: 32'h1D00_FFFF, start: 32'hFFFF_FFFE,
                  count: 32'd3, bp: 1'b0, exp_words: 48, exp_last_w3: 32'h0};
      vecs[2] = '{mt: 32'h0123_4567, ts: 32'h89AB_CDEF, nb: 32'h1702_E6D4, start: 32'h0000_0010,
                  count: 32'd2, bp: 1'b1, exp_words: 32, exp_last_w3: 32'h0000_0011};
      vecs[3] = '{mt: 32'hDEAD_BEEF, ts: 32'h1111_2222, nb: 32'h3333_4444, start: 32'h5555_0000,
                  count: 32'd0, bp: 1'b0, exp_words: 0, exp_last_w3: 32'h0};
      vecs[4] = '{mt: 32'hCAFE_F00D, ts: 32'h0BAD_F00D, nb: 32'h1234_5678, start: 32'hFFFF_FFFF,
                  count: 32'd2, bp: 1'b1, exp_words: 32, exp_last_w3: 32'h0};
      vecs[5] = '{mt: $urandom, ts: $urandom, nb: $urandom, start: 32'h8000_0000,
                  count: 32'd1, bp: 1'b1, exp_words: 16, exp_last_w3: 32'h8000_0000};

      // Reset state.
      rst = 1'b1;
      repeat (2) step();
      check("reset outputs {valid,newblock,w,cur_nonce,done,job_ready}",
            128'({valid, newblock, w, cur_nonce, done, job_ready}), 128'({2'b00, 32'h0, 32'h0, 2'b01}));
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++)
         run_job(vecs[i], $sformatf("vec%0d", i));

      for (int r = 0; r < 3; r++) begin
         rv.mt          = $urandom;
         rv.ts          = $urandom;
         rv.nb          = $urandom;
         rv.start       = $urandom;
         rv.count       = $urandom_range(1, 3);
         rv.bp          = 1'($urandom);
         rv.exp_words   = int'(rv.count) * 16;
         rv.exp_last_w3 = rv.start + rv.count - 32'd1;
         run_job(rv, $sformatf("rand%0d", r));
      end

      // Reset at word 7 of block 2, then a fresh job restarts at its own nonce.
      merkle_tail = 32'h1357_9BDF;
      timestamp   = 32'h2468_ACE0;
      nbits       = 32'h1D00_FFFF;
      nonce_start = 32'h0000_0100;
      nonce_count = 32'd3;
      job_valid   = 1'b1;
      core_ready  = 1'b1;
      step();
      job_valid = 1'b0;
      repeat (23) step();
      check("pre-reset at block2 word7 {valid,newblock,w,cur_nonce}",
            128'({valid, newblock, w, cur_nonce}), 128'({2'b10, 32'h0, 32'h0000_0101}));
      rst = 1'b1;
      step();
      check("mid-block reset {valid,newblock,w,cur_nonce,done,job_ready}",
            128'({valid, newblock, w, cur_nonce, done, job_ready}), 128'({2'b00, 32'h0, 32'h0, 2'b01}));
      rst = 1'b0;
      core_ready = 1'b0;
      rv = '{mt: 32'h7777_1111, ts: 32'h7777_2222, nb: 32'h7777_3333, start: 32'h7777_0000,
             count: 32'd1, bp: 1'b0, exp_words: 16, exp_last_w3: 32'h7777_0000};
      run_job(rv, "after_reset");

`ifdef STREAM_ABORT_EN
      // Abort at word 9 of the first block.
      merkle_tail = 32'hABCD_0001;
      nonce_start = 32'h0000_0040;
      nonce_count = 32'd2;
      job_valid   = 1'b1;
      core_ready  = 1'b1;
      step();
      job_valid = 1'b0;
      repeat (9) step();
      check("abort pre {valid,w,cur_nonce}", 128'({valid, w, cur_nonce}), 128'({1'b1, 32'h0, 32'h0000_0040}));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort done {valid,done,job_ready}", 128'({valid, done, job_ready}), 128'(3'b010));
      step();
      check("abort idle {valid,done,job_ready}", 128'({valid, done, job_ready}), 128'(3'b001));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
